// File: rtl/clk_gate_mgr.sv
// ---------------------------------------------------------------------------
// clk_gate_mgr
//
// Purpose:
//     Per-channel clock gating manager. Each channel runs a small FSM
//     (OFF -> WAKE -> ON -> DRAIN) driven by request/busy levels. A channel
//     is woken by a request, reports wake completion with a one-cycle
//     acknowledge, and is automatically gated again after a programmable
//     number of idle cycles. The gate enable is latched on the falling edge
//     so the gated clocks only ever produce whole high phases.
//
// Parameters:
//     NUM_CH   - number of independently gated channels (1..16)
//     IDLE_W   - width of the idle counter and of i_idle_limit
//     WAKE_CYC - cycles spent in WAKE before acknowledge (1..15)
//
// Ports:
//     i_clk        - source clock, the only clock of the block
//     i_rst_n      - asynchronous active-low reset
//     i_force_on   - global bypass, opens every gate while high
//     i_idle_limit - idle cycles before auto-gating, 0 disables auto-gating
//     i_ch_req     - per-channel wake/activity request (level)
//     i_ch_busy    - per-channel busy indication (level), holds gate open
//     o_gclk       - per-channel gated clock
//     o_ch_on      - per-channel status, high in WAKE, ON and DRAIN
//     o_wake_ack   - per-channel one-cycle pulse on WAKE -> ON
//
// Optional feature (macro CLK_GATE_MGR_STATS_EN):
//     i_stats_clr  - synchronous clear of all gated-cycle counters
//     o_gated_cnt  - NUM_CH x 16-bit saturating counts of gated cycles
// ---------------------------------------------------------------------------
module clk_gate_mgr #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_force_on,
    input  logic [IDLE_W-1:0]    i_idle_limit,
    input  logic [NUM_CH-1:0]    i_ch_req,
    input  logic [NUM_CH-1:0]    i_ch_busy,
`ifdef CLK_GATE_MGR_STATS_EN
    input  logic                 i_stats_clr,
    output logic [NUM_CH*16-1:0] o_gated_cnt,
`endif
    output logic [NUM_CH-1:0]    o_gclk,
    output logic [NUM_CH-1:0]    o_ch_on,
    output logic [NUM_CH-1:0]    o_wake_ack
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_WAKE,
        ST_ON,
        ST_DRAIN
    } state_t;

    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

    logic [NUM_CH-1:0] w_en_d;
    logic [NUM_CH-1:0] r_en_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t            r_state;
        state_t            w_state_nxt;
        logic [3:0]        r_wake_cnt;
        logic [3:0]        w_wake_cnt_nxt;
        logic [IDLE_W-1:0] r_idle_cnt;
        logic [IDLE_W-1:0] w_idle_cnt_nxt;
        logic              r_wake_ack;
        logic              w_wake_ack_nxt;
        logic              w_active;

        assign w_active = i_ch_req[g] | i_ch_busy[g];

        // Channel state, counters and the registered acknowledge pulse.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_state    <= ST_OFF;
                r_wake_cnt <= '0;
                r_idle_cnt <= '0;
                r_wake_ack <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_wake_cnt <= w_wake_cnt_nxt;
                r_idle_cnt <= w_idle_cnt_nxt;
                r_wake_ack <= w_wake_ack_nxt;
            end
        end

        // Next-state logic. The acknowledge is computed here and registered
        // so it is high during the first cycle the channel spends in ON.
        // A request while waking does not restart the wake count, and the
        // limit test uses >= so lowering the limit mid-count still gates.
        always_comb begin
            w_state_nxt    = r_state;
            w_wake_cnt_nxt = r_wake_cnt;
            w_idle_cnt_nxt = r_idle_cnt;
            w_wake_ack_nxt = 1'b0;
            case (r_state)
                ST_OFF: begin
                    if (i_ch_req[g]) begin
                        w_state_nxt    = ST_WAKE;
                        w_wake_cnt_nxt = '0;
                    end
                end
                ST_WAKE: begin
                    if (r_wake_cnt == WAKE_LAST) begin
                        w_state_nxt    = ST_ON;
                        w_wake_ack_nxt = 1'b1;
                        w_idle_cnt_nxt = '0;
                    end else begin
                        w_wake_cnt_nxt = r_wake_cnt + 4'd1;
                    end
                end
                ST_ON: begin
                    if ((i_idle_limit != '0) && (r_idle_cnt >= i_idle_limit)) begin
                        w_state_nxt = ST_DRAIN;
                    end else if (w_active) begin
                        w_idle_cnt_nxt = '0;
                    end else if (r_idle_cnt != '1) begin
                        w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_active) begin
                        w_state_nxt    = ST_ON;
                        w_idle_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_OFF;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end

        assign o_ch_on[g]    = (r_state != ST_OFF);
        assign o_wake_ack[g] = r_wake_ack;
        assign w_en_d[g]     = (r_state != ST_OFF) | i_force_on;
        assign o_gclk[g]     = i_clk & r_en_q[g];

`ifdef CLK_GATE_MGR_STATS_EN
        logic [15:0] r_gated_cnt;

        // Counts rising edges seen while the gate is closed; clear has
        // priority over counting and the count sticks at all-ones.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_gated_cnt <= '0;
            end else if (i_stats_clr) begin
                r_gated_cnt <= '0;
            end else if (!r_en_q[g] && (r_gated_cnt != 16'hFFFF)) begin
                r_gated_cnt <= r_gated_cnt + 16'd1;
            end
        end

        assign o_gated_cnt[g*16 +: 16] = r_gated_cnt;
`endif
    end

    // Enables change only while the clock is low, so the AND gate can never
    // truncate or create a high phase. Reset clears them at once, which
    // deliberately cuts any high phase in progress.
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en_q <= '0;
        end else begin
            r_en_q <= w_en_d;
        end
    end

endmodule
